// File: rtl/branch_target_buffer_if.sv
// branch_target_buffer_if: IF-lookup and EX-resolve signal bundle for the branch target buffer.
// Optional macro BTB_STATS_EN adds the statistics counter outputs.
// master: pipeline side (drives fetch PC and resolve info, receives prediction and redirect).
// slave : BTB side.
interface branch_target_buffer_if;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
    logic [31:0] stat_mispredicts;
`endif
    modport master (
`ifdef BTB_STATS_EN
        input  stat_lookups, stat_hits, stat_mispredicts,
`endif
        output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc
    );
    modport slave (
`ifdef BTB_STATS_EN
        output stat_lookups, stat_hits, stat_mispredicts,
`endif
        input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_hit, pred_taken, pred_target, mispredict, redirect_pc
    );
endinterface

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit hysteresis counters and EX-stage mispredict resolver.
// Ports: clk, rst (sync, active-high); bus (branch_target_buffer_if.slave):
//   lookup  : if_pc -> pred_hit, pred_taken, pred_target (combinational)
//   resolve : ex_* -> mispredict, redirect_pc (combinational); table trained on posedge clk
// Optional macro BTB_STATS_EN adds stat_lookups/stat_hits/stat_mispredicts counters.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input logic clk,
    input logic rst,
    branch_target_buffer_if.slave bus
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 30 - IDX_BITS;
    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit, resolve, wr_en;
    logic [1:0]          ctr_d;
    logic [31:0]         target_d;
    assign if_idx = bus.if_pc[IDX_BITS+1:2];
    assign if_tag = bus.if_pc[31:IDX_BITS+2];
    assign ex_idx = bus.ex_pc[IDX_BITS+1:2];
    assign ex_tag = bus.ex_pc[31:IDX_BITS+2];
    // Asynchronous read: a write in this cycle only becomes visible after the edge.
    assign if_hit          = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign bus.pred_hit    = if_hit;
    assign bus.pred_taken  = if_hit && ctr_q[if_idx][1];
    assign bus.pred_target = (if_hit && ctr_q[if_idx][1]) ? target_q[if_idx] : bus.if_pc + 32'd4;
    assign resolve         = bus.ex_valid && bus.ex_is_branch;
    assign bus.mispredict  = resolve && ((bus.ex_taken != bus.ex_pred_taken) ||
                                         (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
    assign bus.redirect_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
    always_comb begin
        ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        wr_en    = resolve && (ex_hit || bus.ex_taken);
        // Taken from 00 only reaches 01; any other taken lands on 10.
        // Not-taken from 10 softens to 11; any other not-taken drops to 00.
        ctr_d    = !ex_hit ? 2'b10 :
                   bus.ex_taken ? ((ctr_q[ex_idx] == 2'b00) ? 2'b01 : 2'b10) :
                                  ((ctr_q[ex_idx] == 2'b10) ? 2'b11 : 2'b00);
        target_d = bus.ex_taken ? bus.ex_target : target_q[ex_idx];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= target_d;
            ctr_q[ex_idx]    <= ctr_d;
        end
    end
`ifdef BTB_STATS_EN
    logic [31:0] stat_lookups_q, stat_hits_q, stat_mispredicts_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups_q     <= '0;
            stat_hits_q        <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_lookups_q     <= stat_lookups_q + 32'd1;
            stat_hits_q        <= stat_hits_q + {31'd0, if_hit};
            stat_mispredicts_q <= stat_mispredicts_q + {31'd0, bus.mispredict};
        end
    end
    assign bus.stat_lookups     = stat_lookups_q;
    assign bus.stat_hits        = stat_hits_q;
    assign bus.stat_mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: scoreboard bench for branch_target_buffer against a table-level reference model.
module tb_branch_target_buffer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    branch_target_buffer_if bus();
    branch_target_buffer #(.ENTRIES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        misp;
        logic [31:0] redir;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;
    bit known = 0;
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int after_taken [4] = '{1, 2, 2, 2};
    int after_nt    [4] = '{0, 0, 3, 0};
`ifdef BTB_STATS_EN
    logic [31:0] m_look = 0, m_hits = 0, m_misp = 0;
`endif
    function automatic int ix(logic [31:0] pc);
        return int'((pc >> 2) % 32'd16);
    endfunction
    function automatic logic [25:0] tg(logic [31:0] pc);
        return 26'(pc >> 6);
    endfunction
    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.name, ".hit"}, {31'd0, bus.pred_hit}, {31'd0, e.hit});
            chk({e.name, ".taken"}, {31'd0, bus.pred_taken}, {31'd0, e.taken});
            chk({e.name, ".target"}, bus.pred_target, e.target);
            chk({e.name, ".misp"}, {31'd0, bus.mispredict}, {31'd0, e.misp});
            if (e.misp) chk({e.name, ".redir"}, bus.redirect_pc, e.redir);
        end
    end
    task automatic predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
        int i = ix(pc);
        bit h = m_valid[i] && m_tag[i] == tg(pc);
        t   = h && m_ctr[i] >= 2;
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endtask
    task automatic cyc(string n, bit r, logic [31:0] ipc, bit ev, bit eb, logic [31:0] epc,
                       bit et, logic [31:0] etg, bit ept, logic [31:0] eptg);
        exp_t e;
        int j;
        rst = r; bus.if_pc = ipc; bus.ex_valid = ev; bus.ex_is_branch = eb; bus.ex_pc = epc;
        bus.ex_taken = et; bus.ex_target = etg; bus.ex_pred_taken = ept; bus.ex_pred_target = eptg;
        e.name = n;
        j = ix(ipc);
        e.hit = m_valid[j] && m_tag[j] == tg(ipc);
        predict(ipc, e.taken, e.target);
        e.misp  = ev && eb && (et != ept || (et && etg != eptg));
        e.redir = et ? etg : epc + 32'd4;
        if (known) q.push_back(e);
        @(posedge clk);
`ifdef BTB_STATS_EN
        if (r) begin m_look = 0; m_hits = 0; m_misp = 0; end
        else begin m_look++; m_hits += {31'd0, e.hit}; m_misp += {31'd0, e.misp}; end
`endif
        j = ix(epc);
        if (r) begin
            foreach (m_valid[k]) m_valid[k] = 0;
            known = 1;
        end else if (ev && eb) begin
            if (m_valid[j] && m_tag[j] == tg(epc)) begin
                m_ctr[j] = et ? after_taken[m_ctr[j]] : after_nt[m_ctr[j]];
                if (et) m_tgt[j] = etg;
            end else if (et) begin
                m_valid[j] = 1; m_tag[j] = tg(epc); m_tgt[j] = etg; m_ctr[j] = 2;
            end
        end
        #1;
    endtask
    task automatic look(string n, logic [31:0] ipc);
        cyc(n, 0, ipc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask
    task automatic res(string n, logic [31:0] ipc, logic [31:0] epc, bit et, logic [31:0] etg);
        bit pt;
        logic [31:0] ptg;
        predict(epc, pt, ptg);
        cyc(n, 0, ipc, 1, 1, epc, et, etg, pt, ptg);
    endtask
    function automatic logic [31:0] rpc();
        return ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC :
               (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
    endfunction
    initial begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset", 1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
        look("cold", 32'h40);
        res("alloc", 32'h40, 32'h40, 1, 32'h100);
        look("alloc_hit", 32'h40);
        res("walk_nt1", 32'h40, 32'h40, 0, 32'h0);
        look("walk_11", 32'h40);
        res("walk_t1", 32'h40, 32'h40, 1, 32'h100);
        res("walk_nt2", 32'h40, 32'h40, 0, 32'h0);
        res("walk_nt3", 32'h40, 32'h40, 0, 32'h0);
        look("walk_00", 32'h40);
        res("walk_t2", 32'h40, 32'h40, 1, 32'h100);
        look("walk_01", 32'h40);
        res("walk_t3", 32'h40, 32'h40, 1, 32'h100);
        look("walk_10", 32'h40);
        res("alias", 32'h40, 32'h80, 1, 32'h200);
        look("alias_40", 32'h40);
        look("alias_80", 32'h80);
        res("realloc", 32'h80, 32'h40, 1, 32'h100);
        res("same_cycle", 32'h40, 32'h40, 1, 32'h300);
        look("same_next", 32'h40);
        cyc("rst_res", 1, 32'h40, 1, 1, 32'h80, 1, 32'h500, 0, 32'h0);
        look("rst_res_40", 32'h40);
        look("rst_res_80", 32'h80);
        res("stall_pre", 32'h40, 32'h40, 1, 32'h100);
        cyc("stall", 0, 32'h40, 0, 1, 32'h40, 1, 32'h999, 0, 32'h0);
        look("stall_after", 32'h40);
        look("wrap_look", 32'hFFFFFFFC);
        cyc("wrap_res", 0, 32'h0, 1, 1, 32'hFFFFFFFC, 0, 32'h0, 1, 32'h1234);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ipc, epc, etg, ptg;
            bit r, ev, eb, et, pt;
            r   = ($urandom_range(0, 59) == 0);
            ipc = rpc();
            epc = rpc();
            ev  = ($urandom_range(0, 3) != 0);
            eb  = ($urandom_range(0, 3) != 0);
            et  = $urandom_range(0, 1) == 1;
            etg = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : 32'($urandom_range(0, 15)) << 4;
            predict(epc, pt, ptg);
            if ($urandom_range(0, 3) == 0) begin
                pt  = $urandom_range(0, 1) == 1;
                ptg = 32'($urandom_range(0, 15)) << 4;
            end
            cyc("rand", r, ipc, ev, eb, epc, et, etg, pt, ptg);
        end
`ifdef BTB_STATS_EN
        chk("stat_lookups", bus.stat_lookups, m_look);
        chk("stat_hits", bus.stat_hits, m_hits);
        chk("stat_mispredicts", bus.stat_mispredicts, m_misp);
`endif
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
